bscan_stream_bridge: RTL and testbench
======================================

Name: bscan_stream_bridge

Overview:
- Parametrised JTAG USER-DR transport between the BSCAN primitive and user logic, all in the tck domain.
- Upload path: deserialises host frames of DATA_WIDTH bits, buffers them in a FIFO, and presents them as a valid/ready stream.
- Readback path: captures a RESULT_WIDTH result word, optionally prefixed by a status byte, and shifts it out on tdo in the same full-duplex DR scan.
- Supersedes the fixed 8-bit upload / 16-bit readback handling inside user_logic.

Parameters:
- DATA_WIDTH, 8: upload frame and stream word width, 1..64.
- RESULT_WIDTH, 16: readback result width, 1..64.
- FIFO_DEPTH, 16: upload FIFO entries; power of two, 2 or more.
- Constraint: TX_LEN (defined under Behaviour) must differ from DATA_WIDTH. Violation is an elaboration-time $error.

Ports:
- tck  in  1  JTAG clock; the only clock.
- rst_n  in  1  synchronous reset, active-low.
- tdi  in  1  serial data from host, LSB first.
- tdo  out  1  serial data to host.
- test_logic_reset  in  1  TAP in test-logic-reset.
- ir_is_user  in  1  IR holds the USER instruction; all DR activity is ignored when low.
- capture_dr  in  1  TAP capture-DR state.
- shift_dr  in  1  TAP shift-DR state.
- update_dr  in  1  TAP update-DR state.
- m_data  out  DATA_WIDTH  stream word.
- m_valid  out  1  stream word valid.
- m_ready  in  1  downstream accepts m_data.
- result_data  in  RESULT_WIDTH  value returned on readback.
- result_valid  in  1  result_data is final.
- frame_err  out  1  sticky: a malformed frame was seen.
- drop_cnt  out  8  count of words dropped on overflow; saturates at 255.

Behaviour:
- Reset: reset is `rst_n==0` or `test_logic_reset==1`, sampled on tck. It clears:
  - the rx shift register and the bit counter;
  - the tx shift register;
  - the FIFO (m_valid=0, m_data=0);
  - frame_err and drop_cnt (both 0).
  - tdo=0 during reset.
- Qualification: capture/shift/update take effect only when ir_is_user=1.
- Capture (capture_dr):
  - bit_cnt <= 0.
  - tx_sr <= readback frame of TX_LEN bits.
  - TX_LEN = RESULT_WIDTH without the macro, RESULT_WIDTH+8 with it.
- Shift (each tck with shift_dr=1):
  - rx_sr <= {tdi, rx_sr[DATA_WIDTH-1:1]}.
  - tx_sr shifts right with 0 filled in.
  - bit_cnt increments and saturates at 127.
- tdo = tx_sr[0], combinational from the register. The first bit after capture is therefore valid before the first shift edge.
- Update (update_dr), classified by bit_cnt:
  - bit_cnt == DATA_WIDTH: push rx_sr into the FIFO.
  - bit_cnt == 0 or bit_cnt == TX_LEN: readback or empty scan; no push, no error.
  - Any other value: discard and set frame_err.
- FIFO:
  - First-word-fall-through, registered. m_data/m_valid reflect the head entry one cycle after the push edge.
  - Pop when m_valid && m_ready.
  - Push while full with a pop in the same cycle: accepted, no drop.
  - Push while full without a pop: word dropped; drop_cnt increments, saturating at 255.
  - Pop while empty is ignored.
- Sticky flags clear only on reset, or as described under the optional feature.
- m_data stays stable while m_valid=1 && m_ready=0.
- Reset mid-scan: the partial frame is lost; no push and no error.

Optional Feature:
- Macro: BSCAN_STATUS_HEADER_EN.
- Defined: readback frame = {result_data, status[7:0]}, with status shifted first.
  - status[0] = result_valid.
  - status[1] = drop_cnt != 0.
  - status[2] = frame_err.
  - status[7:3] = FIFO occupancy, saturated at 31.
  - A capture_dr clears frame_err and drop_cnt in the same cycle as the snapshot.
- Undefined: readback frame = result_data only. TX_LEN = RESULT_WIDTH. Flags clear only on reset.

Test Plan:
- Upload: with defaults, scan bytes "L68\n" (0x4C 0x36 0x38 0x0A), m_ready=1 -> m_data sequence 0x4C, 0x36, 0x38, 0x0A, each with a one-cycle m_valid; frame_err=0.
- Readback: result_data=0x1234, capture then 16 shifts with tdi=0 -> host collects 0x1234 LSB first; no FIFO push; frame_err=0.
- Short frame: 5-bit scan then update -> no push; frame_err=1 until reset.
- Overflow: m_ready=0, push 20 bytes into FIFO_DEPTH=16 -> 16 words retained in order; drop_cnt=4. Then with m_ready=1 and one more push in a cycle where m_ready=1 with the FIFO full -> word accepted, drop_cnt stays 4.
- Gating/reset: ir_is_user=0 during a full 8-bit scan -> no push. test_logic_reset pulse mid-shift -> FIFO empty, flags 0.
- BSCAN_STATUS_HEADER_EN defined: frame_err=1, drop_cnt=2, 3 words queued, result_valid=1, result_data=0x0BEE, 24-bit readback -> 0x0BEE1F (status 0x1F); a second readback -> status 0x19.

Source files
------------

// File: rtl/bscan_stream_bridge.sv
// JTAG USER-DR transport: serial upload into a FWFT stream FIFO, readback on tdo.
// Define BSCAN_STATUS_HEADER_EN to prefix readback with a status byte.
module bscan_stream_bridge #(
   parameter int DATA_WIDTH   = 8,
   parameter int RESULT_WIDTH = 16,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                    tck,
   input  logic                    rst_n,
   input  logic                    tdi,
   output logic                    tdo,
   input  logic                    test_logic_reset,
   input  logic                    ir_is_user,
   input  logic                    capture_dr,
   input  logic                    shift_dr,
   input  logic                    update_dr,
   output logic [DATA_WIDTH-1:0]   m_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   input  logic [RESULT_WIDTH-1:0] result_data,
   input  logic                    result_valid,
   output logic                    frame_err,
   output logic [7:0]              drop_cnt
);

`ifdef BSCAN_STATUS_HEADER_EN
   localparam int TX_LEN = RESULT_WIDTH + 8;
`else
   localparam int TX_LEN = RESULT_WIDTH;
`endif
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [6:0] DW_CNT = 7'(DATA_WIDTH);
   localparam logic [6:0] TX_CNT = 7'(TX_LEN);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   if (TX_LEN == DATA_WIDTH) begin : g_len_chk
      $error("bscan_stream_bridge: TX_LEN must differ from DATA_WIDTH");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("bscan_stream_bridge: FIFO_DEPTH must be a power of two >= 2");
   end

   logic                  rst;
   logic                  cap;
   logic                  shf;
   logic                  upd;
   logic [DATA_WIDTH-1:0] rx_sr;
   logic [DATA_WIDTH:0]   rx_next;
   logic [TX_LEN-1:0]     tx_sr;
   logic [TX_LEN-1:0]     tx_frame;
   logic [6:0]            bit_cnt;
   logic                  push;
   logic                  bad_frame;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           count;
   logic                  full;
   logic                  pop;
   logic                  push_ok;
   logic                  drop;

   assign rst = !rst_n || test_logic_reset;
   assign cap = ir_is_user && capture_dr;
   assign shf = ir_is_user && shift_dr;
   assign upd = ir_is_user && update_dr;

   assign rx_next   = {tdi, rx_sr};
   assign push      = upd && (bit_cnt == DW_CNT);
   assign bad_frame = upd && !((bit_cnt == DW_CNT) ||
                               (bit_cnt == 7'd0) ||
                               (bit_cnt == TX_CNT));

`ifdef BSCAN_STATUS_HEADER_EN
   logic [4:0] occ;
   logic [7:0] status;
   assign occ      = (32'(count) > 31) ? 5'd31 : 5'(count);
   assign status   = {occ, frame_err, (drop_cnt != 8'd0), result_valid};
   assign tx_frame = {result_data, status};
`else
   assign tx_frame = result_data;
`endif

   // tdo is held low while in reset regardless of stale tx_sr contents
   assign tdo = tx_sr[0] && !rst;

   always_ff @(posedge tck) begin
      if (rst) begin
         rx_sr   <= '0;
         tx_sr   <= '0;
         bit_cnt <= '0;
      end else if (cap) begin
         bit_cnt <= '0;
         tx_sr   <= tx_frame;
      end else if (shf) begin
         rx_sr <= rx_next[DATA_WIDTH:1];
         tx_sr <= tx_sr >> 1;
         if (bit_cnt != 7'd127) begin
            bit_cnt <= bit_cnt + 7'd1;
         end
      end
   end

   assign full    = (count == FULL_CNT);
   assign pop     = m_valid && m_ready;
   assign push_ok = push && (!full || pop);
   assign drop    = push && full && !pop;

   always_ff @(posedge tck) begin
      if (push_ok) begin
         mem[wr_ptr] <= rx_sr;
      end
   end

   always_ff @(posedge tck) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push_ok, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign m_valid = (count != '0);
   assign m_data  = m_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge tck) begin
      if (rst) begin
         frame_err <= 1'b0;
         drop_cnt  <= 8'd0;
      end else
`ifdef BSCAN_STATUS_HEADER_EN
      if (cap) begin
         frame_err <= 1'b0;
         drop_cnt  <= 8'd0;
      end else
`endif
      begin
         if (bad_frame) begin
            frame_err <= 1'b1;
         end
         if (drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_bscan_stream_bridge.sv
// Scoreboard bench for bscan_stream_bridge: directed scans, queue-checked stream.
// Build with BSCAN_STATUS_HEADER_EN to exercise the status header.
module tb_bscan_stream_bridge;

   localparam int DW = 8;
   localparam int RW = 16;
`ifdef BSCAN_STATUS_HEADER_EN
   localparam int TXL = RW + 8;
`else
   localparam int TXL = RW;
`endif

   logic          tck = 1'b0;
   logic          rst_n = 1'b0;
   logic          tdi = 1'b0;
   logic          tlr = 1'b0;
   logic          ir_is_user = 1'b1;
   logic          capture_dr = 1'b0;
   logic          shift_dr = 1'b0;
   logic          update_dr = 1'b0;
   logic          m_ready = 1'b0;
   logic          result_valid = 1'b0;
   logic [RW-1:0] result_data = '0;
   logic          tdo;
   logic          m_valid;
   logic          frame_err;
   logic [DW-1:0] m_data;
   logic [7:0]    drop_cnt;

   int checks = 0;
   int failures = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] e;
   logic [63:0]   g;

   bscan_stream_bridge dut (
      .tck(tck),
      .rst_n(rst_n),
      .tdi(tdi),
      .tdo(tdo),
      .test_logic_reset(tlr),
      .ir_is_user(ir_is_user),
      .capture_dr(capture_dr),
      .shift_dr(shift_dr),
      .update_dr(update_dr),
      .m_data(m_data),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .result_data(result_data),
      .result_valid(result_valid),
      .frame_err(frame_err),
      .drop_cnt(drop_cnt)
   );

   always #5 tck = ~tck;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // monitor: every accepted stream word must match the scoreboard head
   always @(negedge tck) begin
      if (m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%0h required=none", m_data);
         end else begin
            e = exp_q.pop_front();
            chk("stream_word", 64'(m_data), 64'(e));
         end
      end
   end

   task automatic tick();
      @(posedge tck);
      #1;
   endtask

   task automatic scan(input logic [63:0] val, input int n,
                       input bit ready_upd, output logic [63:0] got);
      got = '0;
      capture_dr = 1'b1;
      tick();
      capture_dr = 1'b0;
      shift_dr = 1'b1;
      for (int i = 0; i < n; i++) begin
         got[i] = tdo;
         tdi = val[i];
         tick();
      end
      shift_dr = 1'b0;
      tdi = 1'b0;
      if (ready_upd) m_ready = 1'b1;
      update_dr = 1'b1;
      tick();
      update_dr = 1'b0;
      tick();
   endtask

   task automatic up(input logic [DW-1:0] b, input bit expect_push);
      logic [63:0] dummy;
      if (expect_push) exp_q.push_back(b);
      scan(64'(b), DW, 1'b0, dummy);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
      tick();
      tick();
      chk("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      // reset state
      rst_n = 1'b0;
      tick();
      tick();
      tick();
      chk("rst_tdo", 64'(tdo), 64'd0);
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_data", 64'(m_data), 64'd0);
      chk("rst_frame_err", 64'(frame_err), 64'd0);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      rst_n = 1'b1;
      tick();

      // upload "L68\n"
      m_ready = 1'b1;
      up(8'h4C, 1'b1);
      up(8'h36, 1'b1);
      up(8'h38, 1'b1);
      up(8'h0A, 1'b1);
      wait_drain();
      chk("upload_frame_err", 64'(frame_err), 64'd0);
      chk("upload_m_valid", 64'(m_valid), 64'd0);

      // readback
      result_data = 16'h1234;
      result_valid = 1'b1;
      scan(64'd0, TXL, 1'b0, g);
`ifdef BSCAN_STATUS_HEADER_EN
      chk("readback", g, 64'h12_3401);
`else
      chk("readback", g, 64'h1234);
`endif
      chk("readback_frame_err", 64'(frame_err), 64'd0);
      chk("readback_no_push", 64'(m_valid), 64'd0);

      // short frame
      scan(64'h15, 5, 1'b0, g);
      chk("short_frame_err", 64'(frame_err), 64'd1);
      chk("short_no_push", 64'(m_valid), 64'd0);

      // gated scan
      ir_is_user = 1'b0;
      scan(64'hA5, DW, 1'b0, g);
      ir_is_user = 1'b1;
      tick();
      chk("gated_no_push", 64'(m_valid), 64'd0);
      chk("gated_err_sticky", 64'(frame_err), 64'd1);

      // test_logic_reset mid-shift
      m_ready = 1'b0;
      up(8'h77, 1'b0);
      chk("tlr_pre_valid", 64'(m_valid), 64'd1);
      capture_dr = 1'b1;
      tick();
      capture_dr = 1'b0;
      shift_dr = 1'b1;
      tdi = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      tlr = 1'b1;
      tick();
      tlr = 1'b0;
      shift_dr = 1'b0;
      tdi = 1'b0;
      tick();
      chk("tlr_m_valid", 64'(m_valid), 64'd0);
      chk("tlr_m_data", 64'(m_data), 64'd0);
      chk("tlr_frame_err", 64'(frame_err), 64'd0);
      chk("tlr_drop_cnt", 64'(drop_cnt), 64'd0);
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      m_ready = 1'b0;

      // overflow: 20 pushes into 16 entries
      for (int i = 0; i < 20; i++) begin
         up(8'h10 + 8'(i), i < 16);
      end
`ifdef BSCAN_STATUS_HEADER_EN
      chk("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
`else
      chk("ovf_drop_cnt", 64'(drop_cnt), 64'd4);
`endif
      chk("ovf_head", 64'(m_data), 64'h10);
      exp_q.push_back(8'hF0);
      scan(64'hF0, DW, 1'b1, g);
      wait_drain();
`ifdef BSCAN_STATUS_HEADER_EN
      chk("ovf_full_pop_drop", 64'(drop_cnt), 64'd0);
`else
      chk("ovf_full_pop_drop", 64'(drop_cnt), 64'd4);
`endif
      chk("ovf_frame_err", 64'(frame_err), 64'd0);

`ifdef BSCAN_STATUS_HEADER_EN
      // status header: frame_err=1, drop_cnt=2, 3 words queued
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      m_ready = 1'b0;
      for (int i = 0; i < 16; i++) up(8'h40 + 8'(i), 1'b1);
      up(8'h90, 1'b0);
      update_dr = 1'b1;
      tick();
      update_dr = 1'b0;
      tick();
      shift_dr = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      shift_dr = 1'b0;
      update_dr = 1'b1;
      tick();
      update_dr = 1'b0;
      tick();
      chk("hdr_drop_cnt", 64'(drop_cnt), 64'd2);
      chk("hdr_frame_err", 64'(frame_err), 64'd1);
      m_ready = 1'b1;
      for (int i = 0; i < 13; i++) tick();
      m_ready = 1'b0;
      tick();
      chk("hdr_queued", 64'(exp_q.size()), 64'd3);
      result_data = 16'h0BEE;
      result_valid = 1'b1;
      scan(64'd0, TXL, 1'b0, g);
      chk("hdr_readback1", g, 64'h0B_EE1F);
      scan(64'd0, TXL, 1'b0, g);
      chk("hdr_readback2", g, 64'h0B_EE19);
      chk("hdr_cleared_drop", 64'(drop_cnt), 64'd0);
      chk("hdr_cleared_err", 64'(frame_err), 64'd0);
      m_ready = 1'b1;
      wait_drain();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
